mipi_pattern_tx: RTL and testbench

MIPI_PATTERN_TX -- requirements
Module: mipi_pattern_tx

---
 rtl/mipi_pat_pkg.sv | 20 ++
 rtl/mipi_pat_rom.sv | 25 ++
 rtl/mipi_pattern_tx.sv | 138 +++++++++++++
 tb/tb_mipi_pattern_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/mipi_pat_pkg.sv
// Shared types and pattern constants for the MIPI pattern transmitter.
package mipi_pat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam int PAT_LEN_DEF = 100;
  localparam int PAT_W       = 100;

  // sel = {polarity, state}: state picks clock-like toggle vs. scrambled word,
  // polarity picks the true or inverted form of that word.
  localparam logic [PAT_W-1:0] PAT0 = {25{4'h5}};
  localparam logic [PAT_W-1:0] PAT1 = 100'h9E37A5C1BD806F24A7135C9B2;
  localparam logic [PAT_W-1:0] PAT2 = ~PAT0;
  localparam logic [PAT_W-1:0] PAT3 = ~PAT1;

endpackage

// File: rtl/mipi_pat_rom.sv
// Combinational pattern lookup: one bit of the selected pattern per index.
module mipi_pat_rom
  import mipi_pat_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [6:0] idx,
  output logic       pat_bit
);

  logic [PAT_W-1:0] row;

  // Select the pattern word, then pick the addressed bit (zero beyond the word).
  always_comb begin
    row = PAT0;
    case (sel)
      2'd0:    row = PAT0;
      2'd1:    row = PAT1;
      2'd2:    row = PAT2;
      default: row = PAT3;
    endcase
    pat_bit = 1'b0;
    if (idx < 7'(PAT_W)) pat_bit = row[idx];
  end

endmodule

// File: rtl/mipi_pattern_tx.sv
// Multi-lane serial pattern transmitter with single-shot and continuous modes.
// All outputs are registered; the ROM is addressed with next-cycle sel/index
// so tx lines up with bit_idx in the same cycle.
module mipi_pattern_tx
  import mipi_pat_pkg::*;
#(
  parameter int               LANES    = 1,
  parameter int               PAT_LEN  = PAT_LEN_DEF,
  parameter int               GAP_LEN  = 0,
  parameter logic             IDLE_LVL = 1'b1,
  parameter logic [LANES-1:0] INV_MASK = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       sel,
  input  logic             cont,
  input  logic             abort,
  output logic [LANES-1:0] tx,
  output logic             busy,
  output logic             eoc,
  output logic [6:0]       bit_idx
);

  localparam logic [6:0] LAST_IDX = 7'(PAT_LEN - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_LEN - 1);

  state_e           state_q, state_d;
  logic [6:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       gap_cnt_q, gap_cnt_d;
  logic [1:0]       sel_q, sel_d;
  logic             cont_q, cont_d;
  logic [LANES-1:0] tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             eoc_q, eoc_d;
  logic             pat_bit;

  mipi_pat_rom u_rom (
    .sel     (sel_d),
    .idx     (bit_idx_d),
    .pat_bit (pat_bit)
  );

  // Next-state: frame sequencing, bit down-counter and gap down-counter.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    gap_cnt_d = gap_cnt_q;
    sel_d     = sel_q;
    cont_d    = cont_q;
    case (state_q)
      ST_IDLE: begin
        if (!abort && start) begin
          state_d   = ST_SEND;
          bit_idx_d = LAST_IDX;
          sel_d     = sel;
          cont_d    = cont;
        end
      end
      ST_SEND: begin
        if (abort) begin
          state_d   = ST_IDLE;
          bit_idx_d = 7'd0;
        end else if (bit_idx_q == 7'd0) begin
          if (cont_q && cont) begin
            sel_d  = sel;
            cont_d = 1'b1;
            if (GAP_LEN == 0) begin
              state_d   = ST_SEND;
              bit_idx_d = LAST_IDX;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = GAP_LAST;
            end
          end else begin
            state_d = ST_IDLE;
            cont_d  = 1'b0;
          end
        end else begin
          bit_idx_d = bit_idx_q - 7'd1;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_d   = ST_IDLE;
          gap_cnt_d = 8'd0;
        end else if (gap_cnt_q == 8'd0) begin
          state_d   = ST_SEND;
          bit_idx_d = LAST_IDX;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_idx_d = 7'd0;
        gap_cnt_d = 8'd0;
      end
    endcase
  end

  // Output decode from the next state, so outputs register alongside it.
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    eoc_d  = (state_d == ST_SEND) && (bit_idx_d == 7'd0);
    tx_d   = {LANES{IDLE_LVL}};
    if (state_d == ST_SEND) tx_d = {LANES{pat_bit}} ^ INV_MASK;
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      bit_idx_q <= 7'd0;
      gap_cnt_q <= 8'd0;
      sel_q     <= 2'd0;
      cont_q    <= 1'b0;
      tx_q      <= {LANES{IDLE_LVL}};
      busy_q    <= 1'b0;
      eoc_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      gap_cnt_q <= gap_cnt_d;
      sel_q     <= sel_d;
      cont_q    <= cont_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      eoc_q     <= eoc_d;
    end
  end

  assign tx      = tx_q;
  assign busy    = busy_q;
  assign eoc     = eoc_q;
  assign bit_idx = bit_idx_q;

endmodule

// File: tb/tb_mipi_pattern_tx.sv
// Directed bench for mipi_pattern_tx: two lanes with lane 1 inverted and a
// 3-cycle gap, plus a default-parameter instance for back-to-back frames.
module tb_mipi_pattern_tx;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] sel;
  logic       cont;
  logic       abort;

  logic [1:0] tx2;
  logic       busy2, eoc2;
  logic [6:0] bidx2;

  logic [0:0] tx1;
  logic       busy1, eoc1;
  logic [6:0] bidx1;

  int checks = 0;
  int errors = 0;

  localparam logic [99:0] E_P0 = {25{4'h5}};
  localparam logic [99:0] E_P1 = 100'h9E37A5C1BD806F24A7135C9B2;
  localparam logic [99:0] E_P3 = 100'h61C85A3E427F90DB58ECA364D;

  mipi_pattern_tx #(
    .LANES    (2),
    .PAT_LEN  (100),
    .GAP_LEN  (3),
    .IDLE_LVL (1'b1),
    .INV_MASK (2'b10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sel     (sel),
    .cont    (cont),
    .abort   (abort),
    .tx      (tx2),
    .busy    (busy2),
    .eoc     (eoc2),
    .bit_idx (bidx2)
  );

  mipi_pattern_tx dut0 (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sel     (sel),
    .cont    (cont),
    .abort   (abort),
    .tx      (tx1),
    .busy    (busy1),
    .eoc     (eoc1),
    .bit_idx (bidx1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic pbit(input logic [1:0] s, input int idx);
    logic [99:0] w;
    case (s)
      2'd0:    w = E_P0;
      2'd1:    w = E_P1;
      2'd2:    w = ~E_P0;
      default: w = E_P3;
    endcase
    return w[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"}, 32'(tx2), 32'h3);
    chk({tag, "_busy"}, 32'(busy2), 32'h0);
    chk({tag, "_eoc"}, 32'(eoc2), 32'h0);
    chk({tag, "_idx"}, 32'(bidx2), 32'h0);
  endtask

  // Called on the cycle bit 99 is on tx; returns on the cycle bit 0 is on tx.
  task automatic frame_check(input logic [1:0] s);
    logic b;
    for (int i = 0; i < 100; i++) begin
      b = pbit(s, 99 - i);
      chk("frame_tx", 32'(tx2), 32'({~b, b}));
      chk("frame_idx", 32'(bidx2), 32'(99 - i));
      chk("frame_eoc", 32'(eoc2), 32'(i == 99));
      chk("frame_busy", 32'(busy2), 32'h1);
      if (i < 99) step();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sel = 2'd0; cont = 1'b0; abort = 1'b0;
    step();
    step();
    chk_idle("reset");

    rst = 1'b1;
    step();
    chk_idle("idle_after_rst");

    // Single frame, sel=3
    sel = 2'd3; cont = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    frame_check(2'd3);
    step();
    chk_idle("single_end");

    // Continuous mode with sel change mid-frame and cont drop
    sel = 2'd2; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    sel = 2'd1;
    frame_check(2'd2);
    chk("dut0_eoc_end1", 32'(eoc1), 32'h1);
    step();
    chk("dut0_b2b_idx", 32'(bidx1), 32'd99);
    chk("dut0_b2b_busy", 32'(busy1), 32'h1);
    chk("dut0_b2b_tx", 32'(tx1), 32'(pbit(2'd1, 99)));
    for (int g = 0; g < 3; g++) begin
      chk("gap_tx", 32'(tx2), 32'h3);
      chk("gap_busy", 32'(busy2), 32'h1);
      chk("gap_eoc", 32'(eoc2), 32'h0);
      step();
    end
    cont = 1'b0;
    frame_check(2'd1);
    step();
    chk_idle("cont_drop");
    step();
    chk("no_restart", 32'(busy2), 32'h0);

    // Abort at bit 50, restart one cycle later
    sel = 2'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 49; i++) step();
    chk("abort_pre_idx", 32'(bidx2), 32'd50);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk_idle("abort50");
    step();
    chk("abort_no_eoc", 32'(eoc2), 32'h0);
    start = 1'b1;
    step();
    start = 1'b0;
    frame_check(2'd0);
    step();
    chk_idle("after_restart");

    // Abort coinciding with bit 0 in continuous mode
    sel = 2'd1; cont = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 99; i++) step();
    chk("ab0_eoc_pre", 32'(eoc2), 32'h1);
    abort = 1'b1;
    step();
    abort = 1'b0; cont = 1'b0;
    chk_idle("abort_bit0");

    // Abort and start together in IDLE
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    chk_idle("abort_start");
    step();
    chk("abort_start_next", 32'(busy2), 32'h0);

    // Reset at bit 20 with start held high
    sel = 2'd3; start = 1'b1;
    step();
    for (int i = 0; i < 79; i++) step();
    chk("rst_pre_idx", 32'(bidx2), 32'd20);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_idle("rst_mid");
    step();
    frame_check(2'd3);
    step();
    chk_idle("held_gap");
    step();
    chk("held_restart_idx", 32'(bidx2), 32'd99);
    chk("held_restart_busy", 32'(busy2), 32'h1);
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
